// File: rtl/incr_arbiter.sv
// incr_arbiter: round-robin arbiter sharing one WIDTH-bit incrementer among NREQ requesters
module incr_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_i,
   input  logic [NREQ*WIDTH-1:0] req_data_i,
   output logic [NREQ-1:0]       gnt_o,
   output logic                  res_valid_o,
   output logic [WIDTH-1:0]      res_data_o,
   output logic [IDW-1:0]        res_id_o,
   output logic                  res_wrap_o,
   input  logic                  res_ready_i,
   output logic                  busy_o
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d, id_q, id_d, win;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic             start;
   int               j;

   // descending scan so the requester closest to ptr is written last and wins
   always_comb begin
      win = ptr_q;
      j   = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = int'(ptr_q) + k;
         if (j >= NREQ) j = j - NREQ;
         if (req_i[j]) win = IDW'(j);
      end
   end

   assign start   = (state_q == IDLE) && (|req_i);
   assign state_d = start ? BUSY : ((state_q == BUSY) && res_ready_i) ? IDLE : state_q;
   assign gnt_d   = start ? (NREQ'(1) << win) : '0;
   assign opnd_d  = start ? req_data_i[win*WIDTH +: WIDTH] : opnd_q;
   assign id_d    = start ? win : id_q;
   assign ptr_d   = start ? ((win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1)) : ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         opnd_q  <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         opnd_q  <= opnd_d;
         gnt_q   <= gnt_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign res_valid_o = (state_q == BUSY);
   assign busy_o      = (state_q == BUSY);
   assign res_data_o  = opnd_q + WIDTH'(1);
   assign res_id_o    = id_q;
   assign res_wrap_o  = &opnd_q;
endmodule

// File: tb/tb_incr_arbiter.sv
// tb_incr_arbiter: directed vector table plus hand sequences for reset, backpressure and round-robin
module tb_incr_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] req_data;
   logic [3:0]  gnt;
   logic        res_valid;
   logic [3:0]  res_data;
   logic [1:0]  res_id;
   logic        res_wrap;
   logic        res_ready;
   logic        busy;
   int          errors = 0;
   int          checks = 0;

   typedef struct {
      logic [3:0]  req;
      logic [15:0] data;
      logic [3:0]  gnt;
      logic [1:0]  id;
      logic [3:0]  res;
      logic        wrap;
   } vec_t;
   vec_t vecs[10];

   incr_arbiter #(.NREQ(4), .WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req), .req_data_i(req_data), .gnt_o(gnt),
      .res_valid_o(res_valid), .res_data_o(res_data), .res_id_o(res_id),
      .res_wrap_o(res_wrap), .res_ready_i(res_ready), .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " gnt"}, 32'(gnt), 0);
      chk({tag, " valid"}, 32'(res_valid), 0);
      chk({tag, " data"}, 32'(res_data), 1);
      chk({tag, " id"}, 32'(res_id), 0);
      chk({tag, " wrap"}, 32'(res_wrap), 0);
      chk({tag, " busy"}, 32'(busy), 0);
   endtask

   initial begin
      // data nibbles are {d3,d2,d1,d0}; ptr carries over from row to row
      vecs[0] = '{4'b0100, 16'h0500, 4'b0100, 2'd2, 4'h6, 1'b0};
      vecs[1] = '{4'b0001, 16'h000F, 4'b0001, 2'd0, 4'h0, 1'b1};
      vecs[2] = '{4'b1001, 16'h7002, 4'b1000, 2'd3, 4'h8, 1'b0};
      vecs[3] = '{4'b1001, 16'h7002, 4'b0001, 2'd0, 4'h3, 1'b0};
      vecs[4] = '{4'b1111, 16'hCBA9, 4'b0010, 2'd1, 4'hB, 1'b0};
      vecs[5] = '{4'b1111, 16'hCBA9, 4'b0100, 2'd2, 4'hC, 1'b0};
      vecs[6] = '{4'b1111, 16'hCBA9, 4'b1000, 2'd3, 4'hD, 1'b0};
      vecs[7] = '{4'b1111, 16'hCBA9, 4'b0001, 2'd0, 4'hA, 1'b0};
      vecs[8] = '{4'b0010, 16'h00E0, 4'b0010, 2'd1, 4'hF, 1'b0};
      vecs[9] = '{4'b0001, 16'h0000, 4'b0001, 2'd0, 4'h1, 1'b0};

      rst_n = 1'b0; req = '0; req_data = '0; res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk_reset("reset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 chk_reset("idle after reset");

      foreach (vecs[i]) begin
         @(negedge clk);
         req = vecs[i].req; req_data = vecs[i].data; res_ready = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
         chk($sformatf("v%0d valid", i), 32'(res_valid), 1);
         chk($sformatf("v%0d data", i), 32'(res_data), 32'(vecs[i].res));
         chk($sformatf("v%0d id", i), 32'(res_id), 32'(vecs[i].id));
         chk($sformatf("v%0d wrap", i), 32'(res_wrap), 32'(vecs[i].wrap));
         req = '0;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d idle valid", i), 32'(res_valid), 0);
         chk($sformatf("v%0d idle gnt", i), 32'(gnt), 0);
      end

      // ptr=1 here: backpressure on a grant to requester 1
      @(negedge clk);
      req = 4'b0010; req_data = 16'h0090; res_ready = 1'b0;
      @(posedge clk);
      #1 chk("bp first data", 32'(res_data), 32'hA);
      chk("bp first gnt", 32'(gnt), 32'b0010);
      @(negedge clk);
      req = 4'b1111; req_data = 16'h5555;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d valid", c), 32'(res_valid), 1);
         chk($sformatf("bp%0d data", c), 32'(res_data), 32'hA);
         chk($sformatf("bp%0d id", c), 32'(res_id), 1);
         chk($sformatf("bp%0d gnt", c), 32'(gnt), 0);
      end
      @(negedge clk);
      res_ready = 1'b1; req = '0;
      @(posedge clk);
      #1 chk("bp release valid", 32'(res_valid), 0);
      repeat (2) @(posedge clk);
      #1 chk("ready in idle valid", 32'(res_valid), 0);
      chk("ready in idle gnt", 32'(gnt), 0);

      // ptr=2 now: 0001 grant, then reset asserted mid-BUSY
      @(negedge clk);
      req = 4'b0001; req_data = 16'h0003; res_ready = 1'b0;
      @(posedge clk);
      #1 chk("pre-rst busy", 32'(busy), 1);
      req = '0;
      #1 rst_n = 1'b0;
      #1 chk_reset("async rst");
      @(negedge clk) rst_n = 1'b1;

      // round-robin from reset: grants 0,1,2,3,0 on every second cycle
      @(negedge clk);
      req = 4'b1111; req_data = 16'hCBA9; res_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (c % 2 == 0) begin
            chk($sformatf("rr%0d gnt", c), 32'(gnt), 32'(4'b0001 << ((c / 2) % 4)));
            chk($sformatf("rr%0d id", c), 32'(res_id), 32'((c / 2) % 4));
            chk($sformatf("rr%0d data", c), 32'(res_data), 32'(4'hA + 4'((c / 2) % 4)));
            chk($sformatf("rr%0d valid", c), 32'(res_valid), 1);
         end else begin
            chk($sformatf("rr%0d gnt", c), 32'(gnt), 0);
            chk($sformatf("rr%0d valid", c), 32'(res_valid), 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/incr_arbiter.md
# incr_arbiter

Round-robin arbiter that time-shares one WIDTH-bit incrementer datapath (out = in + 1, modulo 2^WIDTH) among NREQ requesters. Each requester presents an operand with a request. The block grants one requester, captures its operand and presents the incremented result with a valid/ready handshake. It sits between several client blocks and the single shared increment unit, so that no client needs its own adder.

## Interface
- NREQ, 4: number of requesters; legal range 2..8.
- WIDTH, 4: operand and result width in bits.
- IDW, $clog2(NREQ): width of the requester-ID field. Derived; do not override.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  request bit per requester; level, held until granted.
- req_data  in  NREQ*WIDTH  operand per requester; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  out  NREQ  registered one-hot grant pulse, high for exactly one cycle.
- res_valid  out  1  result available.
- res_data  out  WIDTH  captured operand + 1, modulo 2^WIDTH.
- res_id  out  IDW  index of the requester that owns res_data.
- res_wrap  out  1  high when the captured operand was all ones, i.e. the result wrapped to 0.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  high in the BUSY state.

## Operation
- FSM states are IDLE and BUSY. The reset state is IDLE.
- **IDLE, when req != 0:**
  - Select the winner: the first set req bit, scanning upward from ptr with wrap at NREQ.
  - On the edge:
    - gnt[winner] <= 1.
    - Capture the operand opnd <= req_data[winner].
    - res_id <= winner.
    - ptr <= (winner + 1) mod NREQ.
    - State moves to BUSY.
- **IDLE, when req == 0:** nothing changes and gnt stays 0.
- **BUSY:**
  - res_valid = 1.
  - res_data = opnd + 1, truncated to WIDTH bits.
  - res_wrap = (opnd == all ones).
  - gnt = 0 in every BUSY cycle after the first.
  - res_valid && res_ready → IDLE at the edge.
  - res_valid && !res_ready → stay in BUSY. res_data, res_id and res_wrap must be held stable.
- req is ignored while in BUSY. A requester samples gnt and deasserts req, or presents a new operand, before the FSM next returns to IDLE.
- ptr resets to 0, giving requester 0 the highest priority out of reset.
- Fairness: a continuously asserted request is granted within NREQ grants.
- The result is derived from the captured opnd, never live from req_data. Operand changes after the grant must not affect the result.
- Reset values: gnt=0, res_valid=0, res_data=1 (opnd=0), res_id=0, res_wrap=0, busy=0, ptr=0, state=IDLE.
- Reset asserted mid-operation: everything returns to reset values immediately and asynchronously. The pending result is discarded and no handshake completes.

## Timing
- Cycle t: IDLE, req sampled.
- Cycle t+1: gnt pulse, res_valid=1 and busy=1. Grant-to-valid latency is 0 cycles; request-to-valid latency is 1 cycle.
- Handshake at the end of the first cycle in which res_valid && res_ready. The next cycle is IDLE, and a new grant appears one cycle after that.
- Peak throughput is one result per 2 cycles, reached with res_ready tied high.
- res_ready high in IDLE has no effect.
- req and res_ready changing in the same cycle: only the current state's rule applies. In IDLE, req is evaluated and res_ready is ignored. In BUSY, res_ready is evaluated and req is ignored.
- gnt and res_valid are registered outputs. res_data and res_wrap are combinational from the opnd register only.

## Test plan
- **Reset:** rst_n=0 then released with req=0.
  - All outputs hold their reset values.
  - Asserting rst_n=0 during BUSY clears res_valid and gnt within the same cycle.
- **Single request:** req=4'b0100, data[2]=4'h5, res_ready=1.
  - gnt=4'b0100 for one cycle.
  - res_data=4'h6, res_id=2, res_wrap=0.
  - Then IDLE.
- **Wrap:** req=4'b0001, data[0]=4'hF.
  - res_data=4'h0, res_wrap=1.
- **Round-robin:** all req=4'b1111 held, res_ready=1.
  - Grants are 0,1,2,3,0 on every second cycle.
  - res_id follows the same order, and each res_data equals that requester's operand + 1.
- **Backpressure:** granted data=4'h9, res_ready=0 for 5 cycles.
  - res_valid stays 1 and res_data stays 4'hA.
  - Changing req_data or req has no effect.
  - Raising res_ready returns the FSM to IDLE after one cycle.
- **Pointer skip:** ptr=1 after a grant to 0; req=4'b1001.
  - The next grant is 3, not 0.
  - Then ptr=0 and the following grant is 0.
